// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer owning HI/LO, with D-stage stall request
// Optional build macro: MDU_MADD_EN adds madd/maddu (opcode 0x1C) to the launch and md classes.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DE_IR,
    input  logic [31:0] FD_IR,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Start,
    output logic        Busy,
    output logic        MDStall
);

    logic [5:0]  e_op, e_fn;
    logic        is_launch, is_mul, is_signed, is_madd;
    logic        is_mthi, is_mtlo;
    logic [3:0]  count;
    logic [31:0] p_hi, p_lo;
    logic [31:0] res_hi, res_lo;
    logic [63:0] prod_s, prod_u, prod;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;
    logic [3:0]  cnt_load;
    logic        unused_ir;

    function automatic logic md_class(input logic [31:0] ir);
        logic hit;
        hit = 1'b0;
        if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                6'h10, 6'h11, 6'h12, 6'h13,
                6'h18, 6'h19, 6'h1a, 6'h1b: hit = 1'b1;
                default:                    hit = 1'b0;
            endcase
        end
`ifdef MDU_MADD_EN
        if (ir[31:26] == 6'h1c && (ir[5:0] == 6'h00 || ir[5:0] == 6'h01))
            hit = 1'b1;
`endif
        return hit;
    endfunction

    assign e_op      = DE_IR[31:26];
    assign e_fn      = DE_IR[5:0];
    assign unused_ir = ^{DE_IR[25:6], FD_IR[25:6]};

    always_comb begin
        is_launch = 1'b0;
        is_mul    = 1'b0;
        is_signed = 1'b0;
        is_madd   = 1'b0;
        if (e_op == 6'h00) begin
            case (e_fn)
                6'h18: begin is_launch = 1'b1; is_mul = 1'b1; is_signed = 1'b1; end
                6'h19: begin is_launch = 1'b1; is_mul = 1'b1; end
                6'h1a: begin is_launch = 1'b1; is_signed = 1'b1; end
                6'h1b: begin is_launch = 1'b1; end
                default: ;
            endcase
        end
`ifdef MDU_MADD_EN
        if (e_op == 6'h1c) begin
            case (e_fn)
                6'h00: begin is_launch = 1'b1; is_mul = 1'b1; is_signed = 1'b1; is_madd = 1'b1; end
                6'h01: begin is_launch = 1'b1; is_mul = 1'b1; is_madd = 1'b1; end
                default: ;
            endcase
        end
`endif
    end

    assign is_mthi = (e_op == 6'h00) && (e_fn == 6'h11);
    assign is_mtlo = (e_op == 6'h00) && (e_fn == 6'h13);

    // Sign-extend to 64 bits so one unsigned multiply yields the exact signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'h0, A} * {32'h0, B};
    assign prod   = is_signed ? prod_s : prod_u;
    assign quot_s = $signed(A) / $signed(B);
    assign rem_s  = $signed(A) % $signed(B);
    assign quot_u = A / B;
    assign rem_u  = A % B;

    always_comb begin
        res_hi = HI;
        res_lo = LO;
        if (is_mul) begin
            if (is_madd)
                {res_hi, res_lo} = {HI, LO} + prod;
            else
                {res_hi, res_lo} = prod;
        end else if (B != 32'h0) begin
            if (is_signed) begin
                res_hi = rem_s;
                res_lo = quot_s;
            end else begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
        end
    end

    assign cnt_load = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    assign Busy     = (count != 4'd0);
    assign Start    = is_launch & ~Busy;
    assign MDStall  = (Start | Busy) & md_class(FD_IR);

    always_ff @(posedge clk) begin
        if (reset) begin
            HI    <= 32'h0;
            LO    <= 32'h0;
            p_hi  <= 32'h0;
            p_lo  <= 32'h0;
            count <= 4'd0;
        end else begin
            if (Start) begin
                p_hi  <= res_hi;
                p_lo  <= res_lo;
                count <= cnt_load;
            end else if (Busy) begin
                count <= count - 4'd1;
                if (count == 4'd1) begin
                    HI <= p_hi;
                    LO <= p_lo;
                end
            end
            // Start and mthi/mtlo come from the same E-stage IR, so they never collide.
            if (is_mthi && !Busy) HI <= A;
            if (is_mtlo && !Busy) LO <= A;
        end
    end

endmodule
